// File: rtl/alu_shift_pkg.sv
// rtl/alu_shift_pkg.sv - shared types and decode for the shifter issue stage
// Op codes, shifter control encodings, the decoded entry and the op decoder.
package alu_shift_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int TAG_W   = 4;
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010
  } op_e;

  typedef enum logic [1:0] {
    SH_LEFT = 2'b01,
    SH_SRA  = 2'b10,
    SH_SRL  = 2'b11
  } shift_e;

  typedef struct packed {
    shift_e               shift;
    logic [WIDTH-1:0]     data;
    logic [SHAMT_W-1:0]   shamt;
    logic [TAG_W-1:0]     tag;
    logic                 illegal;
  } entry_t;

  localparam entry_t ENTRY_RST = '{
    shift:   SH_SRL,
    data:    '0,
    shamt:   '0,
    tag:     '0,
    illegal: 1'b0
  };

  // Illegal ops become a logical right shift by zero so the shifter passes rs1 through.
  function automatic entry_t decode_op(
    input logic [2:0]         op,
    input logic [WIDTH-1:0]   rs1,
    input logic [WIDTH-1:0]   rs2,
    input logic [SHAMT_W-1:0] imm,
    input logic               use_imm,
    input logic [TAG_W-1:0]   tag
  );
    entry_t e;
    e.data    = rs1;
    e.tag     = tag;
    e.illegal = 1'b0;
    e.shamt   = use_imm ? imm : rs2[SHAMT_W-1:0];
    case (op)
      OP_SLL:  e.shift = SH_LEFT;
      OP_SRL:  e.shift = SH_SRL;
      OP_SRA:  e.shift = SH_SRA;
      default: begin
        e.shift   = SH_SRL;
        e.shamt   = '0;
        e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/shift_issue_stage_if.sv
// rtl/shift_issue_stage_if.sv - request and shifter-operand handshake bundle
// master drives requests and consumes operands; slave is the issue stage.
interface shift_issue_stage_if;
  import alu_shift_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_op;
  logic [WIDTH-1:0]     in_rs1;
  logic [WIDTH-1:0]     in_rs2;
  logic [SHAMT_W-1:0]   in_imm;
  logic                 in_use_imm;
  logic [TAG_W-1:0]     in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_shift;
  logic [WIDTH-1:0]     out_data;
  logic [SHAMT_W-1:0]   out_shamt;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_illegal;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_imm, in_use_imm, in_tag, out_ready,
    input  in_ready, out_valid, out_shift, out_data, out_shamt, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_imm, in_use_imm, in_tag, out_ready,
    output in_ready, out_valid, out_shift, out_data, out_shamt, out_tag, out_illegal
  );

endinterface

// File: rtl/skid_buf_2.sv
// rtl/skid_buf_2.sv - two-entry valid/ready skid buffer with registered ready
// MAIN drives the output and only changes on load, so a stalled output is stable.
module skid_buf_2 #(
  parameter int           W        = 8,
  parameter logic [W-1:0] RST_DATA = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);

  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept, xfer;

  assign s_ready_o = !skid_v_q;
  assign m_valid_o = main_v_q;
  assign m_data_o  = main_q;
  assign accept    = s_valid_i && !skid_v_q && !flush_i;
  assign xfer      = main_v_q && m_ready_i;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || xfer) begin
      // MAIN is free this cycle: an older skid entry always wins over a new request.
      if (skid_v_q) begin
        main_v_d = 1'b1;
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_v_d = 1'b1;
        main_d   = s_data_i;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_v_d = 1'b1;
      skid_d   = s_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= RST_DATA;
      skid_q   <= RST_DATA;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - registered issue stage feeding the 32-bit shifter
// Decodes requests at accept, buffers them in a 2-entry skid and counts transfers.
module shift_issue_stage
  import alu_shift_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  shift_issue_stage_if.slave     bus,
  output logic [CNT_W-1:0]       issued_cnt
);

  entry_t             in_entry;
  entry_t             main_entry;
  logic               main_valid;
  logic               xfer;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign in_entry = decode_op(bus.in_op, bus.in_rs1, bus.in_rs2,
                              bus.in_imm, bus.in_use_imm, bus.in_tag);

  skid_buf_2 #(
    .W        ($bits(entry_t)),
    .RST_DATA (ENTRY_RST)
  ) u_skid (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush),
    .s_valid_i (bus.in_valid),
    .s_ready_o (bus.in_ready),
    .s_data_i  (in_entry),
    .m_valid_o (main_valid),
    .m_ready_i (bus.out_ready),
    .m_data_o  (main_entry)
  );

  assign bus.out_valid   = main_valid;
  assign bus.out_shift   = main_entry.shift;
  assign bus.out_data    = main_entry.data;
  assign bus.out_shamt   = main_entry.shamt;
  assign bus.out_tag     = main_entry.tag;
  assign bus.out_illegal = main_entry.illegal;

  // A transfer in a flush cycle still completes, so the count ignores flush.
  assign xfer = main_valid && bus.out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - self-checking bench for shift_issue_stage
// Queue model of accepted requests checked every cycle plus literal directed checks.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] issued_cnt;

  shift_issue_stage_if bus();

  shift_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  sh;
    logic [31:0] d;
    logic [4:0]  sa;
    logic [3:0]  tg;
    logic        il;
  } exp_t;

  exp_t        mq[$];
  logic [15:0] m_cnt = 16'h0;
  bit          m_acc, m_xf;

  function automatic exp_t model_decode(logic [2:0] op, logic [31:0] rs1, logic [31:0] rs2,
                                        logic [4:0] imm, logic ui, logic [3:0] tg);
    exp_t e;
    e.d  = rs1;
    e.tg = tg;
    e.il = 1'b0;
    e.sa = ui ? imm : 5'(rs2 % 32);
    if (op == 3'd0)      e.sh = 2'b01;
    else if (op == 3'd1) e.sh = 2'b11;
    else if (op == 3'd2) e.sh = 2'b10;
    else begin
      e.sh = 2'b11;
      e.sa = 5'd0;
      e.il = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the stage is an in-order queue of at most two decoded requests.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_cnt = 16'h0;
    end else begin
      m_acc = bus.in_valid && (mq.size() < 2) && !flush;
      m_xf  = (mq.size() > 0) && bus.out_ready;
      if (m_xf) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 16'h1;
      end
      if (flush) mq.delete();
      else if (m_acc)
        mq.push_back(model_decode(bus.in_op, bus.in_rs1, bus.in_rs2,
                                  bus.in_imm, bus.in_use_imm, bus.in_tag));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
      chk("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
      if (mq.size() > 0) begin
        chk("out_shift", 32'(bus.out_shift), 32'(mq[0].sh));
        chk("out_data", bus.out_data, mq[0].d);
        chk("out_shamt", 32'(bus.out_shamt), 32'(mq[0].sa));
        chk("out_tag", 32'(bus.out_tag), 32'(mq[0].tg));
        chk("out_illegal", 32'(bus.out_illegal), 32'(mq[0].il));
      end
    end
  end

  task automatic drive(logic [2:0] op, logic [31:0] rs1, logic [31:0] rs2,
                       logic [4:0] imm, logic ui, logic [3:0] tg);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_imm     = imm;
    bus.in_use_imm = ui;
    bus.in_tag     = tg;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] shv;
  int          guard;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 4'd0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_cnt", 32'(issued_cnt), 32'd0);
    chk("rst_shift", 32'(bus.out_shift), 32'd3);
    chk("rst_shamt", 32'(bus.out_shamt), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_illegal", 32'(bus.out_illegal), 32'd0);

    // SLL by immediate
    bus.out_ready = 1'b1;
    drive(3'b000, 32'h0000_00F0, 32'h0, 5'd4, 1'b1, 4'd0);
    step();
    bus.in_valid = 1'b0;
    chk("sll_valid", 32'(bus.out_valid), 32'd1);
    chk("sll_shift", 32'(bus.out_shift), 32'd1);
    chk("sll_shamt", 32'(bus.out_shamt), 32'd4);
    chk("sll_data", bus.out_data, 32'h0000_00F0);
    shv = bus.out_data << bus.out_shamt;
    chk("sll_shifter", shv, 32'h0000_0F00);
    step();
    chk("sll_cnt", 32'(issued_cnt), 32'd1);

    // SRA by rs2, upper rs2 bits ignored
    drive(3'b010, 32'h8000_0000, 32'hFFFF_FFE3, 5'd17, 1'b0, 4'd3);
    step();
    bus.in_valid = 1'b0;
    chk("sra_shift", 32'(bus.out_shift), 32'd2);
    chk("sra_shamt", 32'(bus.out_shamt), 32'd3);
    chk("sra_data", bus.out_data, 32'h8000_0000);
    step();
    chk("sra_cnt", 32'(issued_cnt), 32'd2);

    // Stall with two entries, then drain in order
    bus.out_ready = 1'b0;
    drive(3'b001, 32'hAAAA_0000, 32'h0, 5'd7, 1'b1, 4'd1);
    step();
    chk("stall_ready1", 32'(bus.in_ready), 32'd1);
    drive(3'b000, 32'h0000_5555, 32'h0, 5'd2, 1'b1, 4'd2);
    step();
    bus.in_valid = 1'b0;
    chk("stall_ready0", 32'(bus.in_ready), 32'd0);
    chk("stall_tag_a", 32'(bus.out_tag), 32'd1);
    step();
    chk("stall_tag_b", 32'(bus.out_tag), 32'd1);
    chk("stall_data", bus.out_data, 32'hAAAA_0000);
    chk("stall_shamt", 32'(bus.out_shamt), 32'd7);
    chk("stall_shift", 32'(bus.out_shift), 32'd3);
    bus.out_ready = 1'b1;
    step();
    chk("drain_tag2", 32'(bus.out_tag), 32'd2);
    chk("drain_ready", 32'(bus.in_ready), 32'd1);
    chk("drain_shift", 32'(bus.out_shift), 32'd1);
    chk("drain_cnt3", 32'(issued_cnt), 32'd3);
    step();
    chk("drain_empty", 32'(bus.out_valid), 32'd0);
    chk("drain_cnt4", 32'(issued_cnt), 32'd4);

    // Illegal op passes rs1 unshifted
    drive(3'b111, 32'h1234_5678, 32'h0000_001F, 5'd9, 1'b1, 4'd5);
    step();
    bus.in_valid = 1'b0;
    chk("ill_flag", 32'(bus.out_illegal), 32'd1);
    chk("ill_shift", 32'(bus.out_shift), 32'd3);
    chk("ill_shamt", 32'(bus.out_shamt), 32'd0);
    chk("ill_data", bus.out_data, 32'h1234_5678);
    chk("ill_tag", 32'(bus.out_tag), 32'd5);
    step();
    chk("ill_cnt", 32'(issued_cnt), 32'd5);

    // Flush with both entries full and a request offered
    bus.out_ready = 1'b0;
    drive(3'b000, 32'h6, 32'h0, 5'd1, 1'b1, 4'd6);
    step();
    drive(3'b001, 32'h7, 32'h0, 5'd1, 1'b1, 4'd7);
    step();
    drive(3'b010, 32'h8, 32'h0, 5'd1, 1'b1, 4'd8);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_cnt", 32'(issued_cnt), 32'd5);

    // Flush while transferring and while an acceptable request is offered
    drive(3'b000, 32'h9, 32'h0, 5'd1, 1'b1, 4'd9);
    step();
    drive(3'b000, 32'hA, 32'h0, 5'd1, 1'b1, 4'd10);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flushx_valid", 32'(bus.out_valid), 32'd0);
    chk("flushx_cnt", 32'(issued_cnt), 32'd6);
    step();
    chk("flushx_dropped", 32'(bus.out_valid), 32'd0);

    // Stream until the counter reaches its maximum, then wrap
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      drive(3'(guard), 32'(guard) * 32'h9E37_79B1, 32'(guard), 5'(guard >> 3),
            1'(guard >> 1), 4'(guard));
      step();
      guard++;
    end
    bus.in_valid = 1'b0;
    if (guard >= 70000) begin
      n_vec++;
      n_bad++;
      $display("FAIL wrap_bound: counter target not reached after %0d cycles", guard);
    end
    chk("wrap_pre", 32'(issued_cnt), 32'h0000_FFFF);
    step();
    chk("wrap_zero", 32'(issued_cnt), 32'h0000_0000);
    chk("wrap_empty", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
